// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by both the master and slave sides.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int DIV_W   = 8;

    localparam logic [1:0] CMD_READ_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        TURN,
        RX,
        GUARD
    } spi_state_t;

endpackage

// File: rtl/spi_master_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the cycle just before each sclk edge with a one-cycle strobe.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    logic [DIV_W-1:0] div_cnt;
    logic             half_done;

    assign half_done = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_stb  = half_done && !sclk;
    assign fall_stb  = half_done && sclk;

    // Count out each half-period; when disabled, park sclk low and restart the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master (mode 0): shifts out a 10-bit frame and, for read-data
// commands, shifts an 8-bit response back in after a turnaround.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int TA      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_frame,
    input  logic               miso,
    output logic               sclk,
    output logic               ss_n,
    output logic               mosi,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rx_data
);

    localparam int         CNT_W      = $clog2(FRAME_W + TA + 1);
    localparam logic [8:0] GUARD_LAST = 9'(2 * CLK_DIV - 1);

    spi_state_t         state;
    logic [FRAME_W-2:0] tx_shift;
    logic [DATA_W-2:0]  rx_shift;
    logic [CNT_W-1:0]   rise_cnt;
    logic [8:0]         guard_cnt;
    logic               is_read;
    logic               clk_en;
    logic               rise_stb;
    logic               fall_stb;

    assign clk_en = (state == TX) || (state == TURN) || (state == RX);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Frame sequencer: rise_cnt counts sclk rises within the current phase and
    // each phase ends on the sclk fall that follows its last rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rise_cnt  <= '0;
            guard_cnt <= '0;
            is_read   <= 1'b0;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rise_stb && (rise_cnt != '1)) begin
                rise_cnt <= rise_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift <= tx_frame[FRAME_W-2:0];
                        is_read  <= (tx_frame[FRAME_W-1:FRAME_W-2] == CMD_READ_DATA);
                        mosi     <= tx_frame[FRAME_W-1];
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        rise_cnt <= '0;
                        state    <= TX;
                    end
                end
                TX: begin
                    if (fall_stb) begin
                        if (rise_cnt == CNT_W'(FRAME_W)) begin
                            rise_cnt <= '0;
                            mosi     <= 1'b0;
                            if (!is_read) begin
                                ss_n      <= 1'b1;
                                guard_cnt <= '0;
                                state     <= GUARD;
                            end else if (TA == 0) begin
                                state <= RX;
                            end else begin
                                state <= TURN;
                            end
                        end else begin
                            mosi     <= tx_shift[FRAME_W-2];
                            tx_shift <= {tx_shift[FRAME_W-3:0], 1'b0};
                        end
                    end
                end
                TURN: begin
                    if (fall_stb && (rise_cnt == CNT_W'(TA))) begin
                        rise_cnt <= '0;
                        state    <= RX;
                    end
                end
                RX: begin
                    if (fall_stb) begin
                        rx_shift <= {rx_shift[DATA_W-3:0], miso};
                        if (rise_cnt == CNT_W'(DATA_W)) begin
                            rx_data   <= {rx_shift, miso};
                            ss_n      <= 1'b1;
                            guard_cnt <= '0;
                            state     <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=2/TA=1 and
// CLK_DIV=1/TA=0), each with a behavioural SPI slave on its bus.
module tb_spi_master;

    localparam int TA_A = 1;
    localparam int TA_B = 0;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [9:0] frame_a, frame_b;
    logic       miso_a, miso_b;
    logic       sclk_a, sclk_b;
    logic       ss_n_a, ss_n_b;
    logic       mosi_a, mosi_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [7:0] rx_a, rx_b;

    // Slave models: rise counter, captured MOSI frame, response to return.
    int         edge_a, edge_b;
    logic [9:0] cap_a, cap_b;
    logic [7:0] resp_a, resp_b;

    // Observation mux and per-frame measurements.
    bit   sel_mon;
    logic ss_mon, done_mon, busy_mon, mosi_mon;
    int   r_first_low, r_rise, r_refall, r_done_cyc, r_done_cnt, r_mosi_bad;
    logic r_busy1, r_busy_done;

    int total;
    int bad;

    spi_master #(.CLK_DIV(2), .TA(TA_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_frame(frame_a),
        .miso(miso_a), .sclk(sclk_a), .ss_n(ss_n_a), .mosi(mosi_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a)
    );

    spi_master #(.CLK_DIV(1), .TA(TA_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_frame(frame_b),
        .miso(miso_b), .sclk(sclk_b), .ss_n(ss_n_b), .mosi(mosi_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b)
    );

    assign ss_mon   = sel_mon ? ss_n_b : ss_n_a;
    assign done_mon = sel_mon ? done_b : done_a;
    assign busy_mon = sel_mon ? busy_b : busy_a;
    assign mosi_mon = sel_mon ? mosi_b : mosi_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave A: captures MOSI on the first 10 rises, drives the response after TA turnaround rises.
    always @(posedge sclk_a or posedge ss_n_a) begin
        if (ss_n_a) begin
            edge_a = 0;
            miso_a = 1'b0;
        end else begin
            edge_a = edge_a + 1;
            if (edge_a <= 10)
                cap_a = {cap_a[8:0], mosi_a};
            else if (edge_a >= 11 + TA_A && edge_a <= 18 + TA_A)
                miso_a = resp_a[18 + TA_A - edge_a];
        end
    end

    // Slave B: same behaviour for the second instance.
    always @(posedge sclk_b or posedge ss_n_b) begin
        if (ss_n_b) begin
            edge_b = 0;
            miso_b = 1'b0;
        end else begin
            edge_b = edge_b + 1;
            if (edge_b <= 10)
                cap_b = {cap_b[8:0], mosi_b};
            else if (edge_b >= 11 + TA_B && edge_b <= 18 + TA_B)
                miso_b = resp_b[18 + TA_B - edge_b];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue start at cycle 0 (plus optional extra starts s1/s2) and record the frame timeline.
    task automatic applyStimulus(input bit sel, input logic [9:0] frame, input int window,
                                 input int s1, input int s2, input int tx_end);
        sel_mon     = sel;
        r_first_low = -1;
        r_rise      = -1;
        r_refall    = -1;
        r_done_cyc  = -1;
        r_done_cnt  = 0;
        r_mosi_bad  = 0;
        r_busy1     = 1'b0;
        r_busy_done = 1'b1;
        @(negedge clk);
        if (sel) begin frame_b = frame; start_b = 1'b1; end
        else     begin frame_a = frame; start_a = 1'b1; end
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (sel) start_b = (c == s1) || (c == s2);
            else     start_a = (c == s1) || (c == s2);
            if (c == 1) r_busy1 = busy_mon;
            if (!ss_mon) begin
                if (r_first_low < 0) r_first_low = c;
                if (r_rise >= 0 && r_refall < 0) r_refall = c;
                if (r_rise < 0 && c >= tx_end && mosi_mon !== 1'b0) r_mosi_bad++;
            end else if (r_first_low >= 0 && r_rise < 0) begin
                r_rise = c;
            end
            if (done_mon) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc  = c;
                    r_busy_done = busy_mon;
                end
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_seen;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        frame_a = '0;
        frame_b = '0;
        resp_a  = 8'h00;
        resp_b  = 8'h00;
        cap_a   = '0;
        cap_b   = '0;
        sel_mon = 1'b0;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rst_sclk", sclk_a, 0);
        checkOutput("rst_ss_n", ss_n_a, 1);
        checkOutput("rst_mosi", mosi_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_rx", rx_a, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_ss_n", ss_n_a, 1);
        checkOutput("idle_sclk", sclk_a, 0);
        checkOutput("idle_busy", busy_a, 0);
        checkOutput("idle_done", done_a, 0);

        // Write frame, D=2.
        applyStimulus(0, 10'b01_1010_0101, 60, -1, -1, 41);
        checkOutput("wr_first_low", r_first_low, 1);
        checkOutput("wr_ss_rise", r_rise, 41);
        checkOutput("wr_done_cyc", r_done_cyc, 45);
        checkOutput("wr_done_cnt", r_done_cnt, 1);
        checkOutput("wr_busy1", r_busy1, 1);
        checkOutput("wr_busy_done", r_busy_done, 0);
        checkOutput("wr_capture", cap_a, 10'h1A5);
        checkOutput("wr_rx_keep", rx_a, 8'h00);

        // Read frame, D=2, TA=1.
        resp_a = 8'hA5;
        applyStimulus(0, 10'b11_0000_0000, 90, -1, -1, 41);
        checkOutput("rd_first_low", r_first_low, 1);
        checkOutput("rd_ss_rise", r_rise, 77);
        checkOutput("rd_done_cyc", r_done_cyc, 81);
        checkOutput("rd_done_cnt", r_done_cnt, 1);
        checkOutput("rd_mosi_zero", r_mosi_bad, 0);
        checkOutput("rd_capture", cap_a, 10'h300);
        checkOutput("rd_rx", rx_a, 8'hA5);

        // Start pulses while busy are ignored.
        applyStimulus(0, 10'h0F0, 70, 5, 20, 41);
        checkOutput("busy_done_cnt", r_done_cnt, 1);
        checkOutput("busy_ss_rise", r_rise, 41);
        checkOutput("busy_done_cyc", r_done_cyc, 45);
        checkOutput("busy_capture", cap_a, 10'h0F0);
        checkOutput("busy_rx_keep", rx_a, 8'hA5);

        // Back-to-back start in the done cycle.
        applyStimulus(0, 10'h155, 100, 45, -1, 41);
        checkOutput("b2b_done_cnt", r_done_cnt, 2);
        checkOutput("b2b_ss_rise", r_rise, 41);
        checkOutput("b2b_gap", r_refall - r_rise, 5);
        checkOutput("b2b_capture", cap_a, 10'h155);

        // Reset in the middle of a read.
        resp_a  = 8'h3C;
        frame_a = 10'h300;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (13) @(negedge clk);
        checkOutput("mid_busy_pre", busy_a, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_sclk", sclk_a, 0);
        checkOutput("mid_ss_n", ss_n_a, 1);
        checkOutput("mid_mosi", mosi_a, 0);
        checkOutput("mid_busy", busy_a, 0);
        checkOutput("mid_done", done_a, 0);
        checkOutput("mid_rx", rx_a, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        checkOutput("mid_no_done", done_seen, 0);
        applyStimulus(0, 10'h2C3, 60, -1, -1, 41);
        checkOutput("post_done_cyc", r_done_cyc, 45);
        checkOutput("post_capture", cap_a, 10'h2C3);
        checkOutput("post_rx_keep", rx_a, 8'h00);

        // Read with D=1, TA=0.
        resp_b = 8'h3C;
        applyStimulus(1, 10'b11_0000_0000, 50, -1, -1, 21);
        checkOutput("d1_first_low", r_first_low, 1);
        checkOutput("d1_ss_rise", r_rise, 37);
        checkOutput("d1_done_cyc", r_done_cyc, 39);
        checkOutput("d1_done_cnt", r_done_cnt, 1);
        checkOutput("d1_mosi_zero", r_mosi_bad, 0);
        checkOutput("d1_capture", cap_b, 10'h300);
        checkOutput("d1_rx", rx_b, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
